// File: rtl/div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle signed restoring divider with HI/LO result pair
//               and hazard-unit stall output for the MIPS execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        div_start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_mf_hi,
    input  logic        is_mf_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        div_by_zero
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_fixup = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_count;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic [31:0] r_dvd_orig;
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_dvz;

    logic [31:0] w_dvd_abs;
    logic [31:0] w_dvsr_abs;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_take;

    assign w_dvd_abs  = dividend[31] ? (~dividend + 32'd1) : dividend;
    assign w_dvsr_abs = divisor[31]  ? (~divisor  + 32'd1) : divisor;

    // r_quo starts as |dividend| and shifts out its MSB while quotient bits shift in.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {2'b00, r_dvsr};
    assign w_take  = ~w_diff[33];

    assign busy  = (r_state != c_st_idle);
    assign stall = busy & (is_mf_hi | is_mf_lo | div_start);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (div_start) begin
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                if (r_count == 5'd0) begin
                    w_state_next = c_st_fixup;
                end
            end
            c_st_fixup: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= 5'd0;
            r_rem       <= 33'd0;
            r_quo       <= 32'd0;
            r_dvsr      <= 32'd0;
            r_dvd_orig  <= 32'd0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dvz       <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (div_start) begin
                        r_rem      <= 33'd0;
                        r_quo      <= w_dvd_abs;
                        r_dvsr     <= w_dvsr_abs;
                        r_dvd_orig <= dividend;
                        r_q_neg    <= dividend[31] ^ divisor[31];
                        r_r_neg    <= dividend[31];
                        r_dvz      <= (divisor == 32'd0);
                        r_count    <= 5'd31;
                    end
                end
                c_st_run: begin
                    r_rem <= w_take ? w_diff[32:0] : w_shift[32:0];
                    r_quo <= {r_quo[30:0], w_take};
                    if (r_count != 5'd0) begin
                        r_count <= r_count - 5'd1;
                    end
                end
                c_st_fixup: begin
                    // A zero divisor overrides whatever the magnitude loop produced.
                    if (r_dvz) begin
                        lo          <= 32'hFFFF_FFFF;
                        hi          <= r_dvd_orig;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo <= r_q_neg ? (~r_quo + 32'd1) : r_quo;
                        hi <= r_r_neg ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
